// File: rtl/satarx_crc.sv
// satarx_crc: SATA link-layer receive CRC checker.
// Recomputes CRC-32 over each frame's payload dwords and strips the
// trailing CRC dword. The last payload dword is re-marked with TLAST.
// A mismatch sets TUSER on that beat and pulses o_crc_err.
// A CRC dword with no payload in front of it (a runt) also pulses o_crc_err.
module satarx_crc #(
  parameter logic [31:0] POLYNOMIAL   = 32'h04c1_1db7,
  parameter logic [31:0] INITIAL_CRC  = 32'h5232_5032,
  parameter logic        OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TUSER,
  output logic        o_crc_err
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [31:0] hold_data_reg, hold_data_next;
  logic        m_valid_reg, m_last_reg, m_user_reg;
  logic [31:0] m_data_reg;
  logic        crc_err_reg;
  logic        accept;
  logic        emit, emit_last, emit_user, err_next;

  // Shifts one dword into the CRC, MSB first, with no reflection or final inversion.
  function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                           input logic [31:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int k = 0; k < 32; k++) begin
      if (c[31] ^ data[31-k])
        c = {c[30:0], 1'b0} ^ POLYNOMIAL;
      else
        c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Each accept produces at most one output beat.
  // Taking input whenever the output slot is free or draining keeps full throughput.
  assign S_AXIS_TREADY = !m_valid_reg || M_AXIS_TREADY;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

  // Next state: the held dword is released when the following beat arrives.
  // If that beat is the CRC, the released dword is the frame's last payload dword.
  always_comb begin
    state_next     = state_reg;
    crc_next       = crc_reg;
    hold_data_next = hold_data_reg;
    emit           = 1'b0;
    emit_last      = 1'b0;
    emit_user      = 1'b0;
    err_next       = 1'b0;
    if (accept) begin
      if (S_AXIS_TLAST) begin
        crc_next   = INITIAL_CRC;
        state_next = S_EMPTY;
        if (state_reg == S_HELD) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          emit_user = (crc_reg != S_AXIS_TDATA);
          err_next  = emit_user;
        end else begin
          // Runt: a CRC dword with no payload is dropped and flagged.
          err_next = 1'b1;
        end
      end else begin
        crc_next       = crc_step(crc_reg, S_AXIS_TDATA);
        hold_data_next = S_AXIS_TDATA;
        state_next     = S_HELD;
        emit           = (state_reg == S_HELD);
      end
    end
  end

  // State, running CRC and hold buffer; all frozen under back-pressure because accept is low.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg     <= S_EMPTY;
      crc_reg       <= INITIAL_CRC;
      hold_data_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      crc_reg       <= crc_next;
      hold_data_reg <= hold_data_next;
    end
  end

  // Output register: load on emit, otherwise retire the beat once it is taken.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= 32'd0;
      m_last_reg  <= 1'b0;
      m_user_reg  <= 1'b0;
    end else if (emit) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= hold_data_reg;
      m_last_reg  <= emit_last;
      m_user_reg  <= emit_user;
    end else if (M_AXIS_TREADY) begin
      m_valid_reg <= 1'b0;
      if (OPT_LOWPOWER) begin
        m_data_reg <= 32'd0;
        m_last_reg <= 1'b0;
        m_user_reg <= 1'b0;
      end
    end
  end

  // Error pulse lines up with the flagged beat first becoming valid, regardless of TREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)
      crc_err_reg <= 1'b0;
    else
      crc_err_reg <= err_next;
  end

  assign M_AXIS_TVALID = m_valid_reg;
  assign M_AXIS_TDATA  = m_data_reg;
  assign M_AXIS_TLAST  = m_last_reg;
  assign M_AXIS_TUSER  = m_user_reg;
  assign o_crc_err     = crc_err_reg;

endmodule

// File: tb/tb_satarx_crc.sv
// tb_satarx_crc: scoreboard bench for satarx_crc.
// The stimulus side queues the beats and error pulses it expects.
// A negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_satarx_crc;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tuser;
  logic        crc_err;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  bit    err_q[$];   // 1: pulse must align with a TLAST/TUSER beat, 0: runt pulse
  int    checks = 0;
  int    errors = 0;
  int    stalls = 0;
  int    beats_seen = 0;
  bit    bp_mode = 0;
  bit    mon_en = 0;

  satarx_crc dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TUSER  (m_tuser),
    .o_crc_err     (crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC: shift register model, one bit at a time.
  function automatic logic [31:0] model_crc(input logic [31:0] pl[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'h5232_5032;
    foreach (pl[i]) begin
      for (int b = 31; b >= 0; b--) begin
        fb = c[31] ^ pl[i][b];
        c  = c << 1;
        if (fb) c = c ^ 32'h04c1_1db7;
      end
    end
    return c;
  endfunction

  // Back-pressure pattern 1,0,0,1,0,1 repeating, updated just after each rising edge.
  initial begin
    int idx;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_tready = pat[idx];
        idx = (idx + 1) % 6;
      end else begin
        idx = 0;
      end
    end
  end

  // Monitor: scoreboard pops, error pulse alignment, stall stability, low-power zeros.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_l, prev_u;
    bit          al;
    beat_t       e;
    prev_stall = 0;
    prev_d = '0;
    prev_l = 0;
    prev_u = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l || m_tuser !== prev_u) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%08h l=%0b u=%0b, required v=1 d=%08h l=%0b u=%0b",
                   m_tvalid, m_tdata, m_tlast, m_tuser, prev_d, prev_l, prev_u);
        end
      end
      if (m_tvalid && !m_tready) begin
        checks++;
        if (s_tready !== 1'b0) begin
          errors++;
          $display("FAIL s_tready_stall: got %0b, required 0", s_tready);
        end
      end else if (s_tready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL s_tready_free: got %0b, required 1", s_tready);
      end
      if (!m_tvalid && (m_tdata !== 32'd0 || m_tlast !== 1'b0 || m_tuser !== 1'b0)) begin
        checks++;
        errors++;
        $display("FAIL lowpower_idle: got d=%08h l=%0b u=%0b, required all zero", m_tdata, m_tlast, m_tuser);
      end
      if (crc_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL crc_err_unexpected: got pulse, required none");
        end else begin
          al = err_q.pop_front();
          if (al && !(m_tvalid && m_tlast && m_tuser)) begin
            errors++;
            $display("FAIL crc_err_align: got v=%0b l=%0b u=%0b, required 1 1 1", m_tvalid, m_tlast, m_tuser);
          end
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        beats_seen++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got d=%08h l=%0b u=%0b, required no beat", m_tdata, m_tlast, m_tuser);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.d || m_tlast !== e.l || m_tuser !== e.u) begin
            errors++;
            $display("FAIL beat: got d=%08h l=%0b u=%0b, required d=%08h l=%0b u=%0b",
                     m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
          end else begin
            $display("beat ok d=%08h l=%0b u=%0b", m_tdata, m_tlast, m_tuser);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
      prev_u = m_tuser;
    end
  end

  // Present one beat and wait for the edge that accepts it; TVALID is left high.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      stalls++;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept in 100 cycles, required accept");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tdata  = 32'd0;
    s_tlast  = 1'b0;
  endtask

  // Queue expectations for a frame, then send payload and CRC (optionally corrupted).
  task automatic send_frame(input logic [31:0] pl[$], input bit bad);
    logic [31:0] c;
    beat_t       e;
    c = model_crc(pl);
    if (bad) c = c ^ 32'h0000_0001;
    foreach (pl[i]) begin
      e.d = pl[i];
      e.l = (i == pl.size() - 1);
      e.u = bad && (i == pl.size() - 1);
      exp_q.push_back(e);
    end
    if (bad) err_q.push_back(1'b1);
    foreach (pl[i]) send_beat(pl[i], 1'b0);
    send_beat(c, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d beats and %0d pulses pending, required 0", name, exp_q.size(), err_q.size());
      exp_q.delete();
      err_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end else begin
      $display("check ok %s = %08h", name, got);
    end
  endtask

  initial begin
    logic [31:0] f3[$];
    logic [31:0] f4[$];
    logic [31:0] f2[$];
    logic [31:0] f1[$];
    int          b0;
    f3 = '{32'h0000_0001, 32'h1234_5678, 32'hdead_beef};
    f4 = '{32'hcafe_f00d, 32'h0000_0000, 32'hffff_ffff, 32'h8000_0001};
    f2 = '{32'ha5a5_5a5a, 32'h0f0f_f0f0};
    f1 = '{32'h1111_2222};
    rst_n    = 1'b0;
    m_tready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_val("reset_tdata", m_tdata, 32'd0);
    check_val("reset_tlast_tuser", {30'd0, m_tlast, m_tuser}, 32'd0);
    check_val("reset_crc_err", {31'd0, crc_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Good frame at full rate.
    stalls = 0;
    b0 = beats_seen;
    send_frame(f3, 0);
    idle();
    drain("good");
    check_val("good_stalls", stalls, 0);
    check_val("good_beats", beats_seen - b0, 3);

    // Same frame, corrupted CRC.
    send_frame(f3, 1);
    idle();
    drain("bad");

    // Runt, followed by a good frame.
    b0 = beats_seen;
    err_q.push_back(1'b0);
    send_beat(32'h5232_5032, 1'b1);
    idle();
    drain("runt");
    check_val("runt_beats", beats_seen - b0, 0);
    send_frame(f2, 0);
    idle();
    drain("after_runt");

    // Back-pressure.
    bp_mode = 1;
    b0 = beats_seen;
    send_frame(f4, 0);
    idle();
    drain("backpressure");
    bp_mode = 0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    check_val("bp_beats", beats_seen - b0, 4);

    // Back-to-back: good, bad, good with continuous TVALID.
    send_frame(f3, 0);
    send_frame(f4, 1);
    send_frame(f1, 0);
    idle();
    drain("b2b");

    // Reset mid-frame with the first dword stuck on the output.
    m_tready = 1'b0;
    send_beat(32'h7777_0000, 1'b0);
    send_beat(32'h7777_0001, 1'b0);
    idle();
    #3;
    check_val("pre_reset_tvalid", {31'd0, m_tvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_reset_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_val("async_reset_tdata", m_tdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(f3, 0);
    idle();
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200us");
    $fatal(1, "timeout");
  end

endmodule
